clock_domain_sequencer: RTL and testbench

//  Controller in front of clock_gating_unit: owns its domain_enable and power_mode inputs.

---
 rtl/pwr_pkg.sv | 24 ++
 rtl/clock_domain_sequencer_if.sv | 37 +++
 rtl/rr_priority_picker.sv | 32 +++
 rtl/clock_domain_sequencer.sv | 152 +++++++++++++++
 tb/tb_clock_domain_sequencer.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwr_pkg
// Purpose  : Shared types and constants for the clock-domain sequencer.
// Revision : 1.0
// ============================================================================
package pwr_pkg;

   localparam int NUM_DOMAINS_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      GRANT      = 2'd1,
      WAIT_VALID = 2'd2,
      SPACING    = 2'd3
   } seq_state_t;

   localparam logic [7:0] PM_ACTIVE = 8'h00;
   localparam logic [7:0] PM_LIGHT  = 8'h01;
   localparam logic [7:0] PM_DEEP   = 8'h02;
   localparam logic [7:0] PM_OFF    = 8'h03;

endpackage
`default_nettype wire

// File: rtl/clock_domain_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : clock_domain_sequencer_if
// Purpose  : Request/status bundle between domain clients and the sequencer.
// Revision : 1.0
// ============================================================================
interface clock_domain_sequencer_if
   import pwr_pkg::*;
#(
   parameter int NUM_DOMAINS = NUM_DOMAINS_DEFAULT
);
   logic [NUM_DOMAINS-1:0]       wake_req;
   logic [NUM_DOMAINS-1:0]       sleep_req;
   logic [NUM_DOMAINS-1:0]       activity_detect;
   logic [NUM_DOMAINS-1:0]       clock_valid;
   logic                         auto_sleep_en;
   logic [7:0]                   cfg_power_mode;
   logic [NUM_DOMAINS-1:0]       domain_enable;
   logic [7:0]                   power_mode;
   logic [NUM_DOMAINS-1:0]       wake_ack;
   logic [NUM_DOMAINS-1:0]       wake_err;
   logic [$clog2(NUM_DOMAINS):0] active_count;
   logic                         busy;

   modport master (
      output wake_req, sleep_req, activity_detect, clock_valid,
             auto_sleep_en, cfg_power_mode,
      input  domain_enable, power_mode, wake_ack, wake_err, active_count, busy
   );

   modport slave (
      input  wake_req, sleep_req, activity_detect, clock_valid,
             auto_sleep_en, cfg_power_mode,
      output domain_enable, power_mode, wake_ack, wake_err, active_count, busy
   );
endinterface
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_picker
// Purpose  : First set request at/after ptr, wrapping; one-hot, index and any.
// Revision : 1.0
// ============================================================================
module rr_priority_picker #(
   parameter int N = 16
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] index,
   output logic                 any
);
   always_comb begin
      int j;
      grant = '0;
      index = '0;
      any   = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!any && req[j]) begin
            any      = 1'b1;
            index    = $clog2(N)'(j);
            grant[j] = 1'b1;
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/clock_domain_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : clock_domain_sequencer
// Purpose  : Spaced round-robin wake sequencing, sleep and idle auto-sleep.
// Revision : 1.0
// ============================================================================
module clock_domain_sequencer
   import pwr_pkg::*;
#(
   parameter int NUM_DOMAINS  = NUM_DOMAINS_DEFAULT,
   parameter int WAKE_SPACING = 4,
   parameter int WAKE_TIMEOUT = 32,
   parameter int IDLE_TIMEOUT = 64,
   parameter int MAX_ACTIVE   = 8
) (
   input  logic                     ref_clk,
   input  logic                     rst,
   clock_domain_sequencer_if.slave  bus
);
   localparam int c_IDX_W   = $clog2(NUM_DOMAINS);
   localparam int c_CNT_W   = $clog2(NUM_DOMAINS) + 1;
   localparam int c_TMR_MAX = (WAKE_TIMEOUT > WAKE_SPACING) ? WAKE_TIMEOUT : WAKE_SPACING;
   localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);
   localparam int c_IDL_W   = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [NUM_DOMAINS-1:0] c_ONE = {{(NUM_DOMAINS-1){1'b0}}, 1'b1};

   seq_state_t             r_state, w_next_state;
   logic [c_IDX_W-1:0]     r_ptr, r_g;
   logic [c_TMR_W-1:0]     r_tmr;
   logic [NUM_DOMAINS-1:0] r_enable, r_ack, r_err;
   logic [c_CNT_W-1:0]     r_active, w_popcount;
   logic [7:0]             r_power_mode;
   logic [c_IDL_W-1:0]     r_idle [NUM_DOMAINS];

   logic [NUM_DOMAINS-1:0] w_pending, w_g_onehot, w_defer;
   logic [NUM_DOMAINS-1:0] w_sleep_clr, w_auto_clr, w_timeout_clr;
   logic [NUM_DOMAINS-1:0] w_pick_grant;
   logic [c_IDX_W-1:0]     w_pick_idx;
   logic                   w_pick_any;
   logic                   w_do_grant, w_do_ack, w_do_timeout;

   assign w_pending     = bus.wake_req & ~bus.sleep_req & ~r_enable & ~r_err;
   assign w_g_onehot    = c_ONE << r_g;
   // The domain being woken keeps its clock until the wake resolves.
   assign w_defer       = (r_state == WAIT_VALID) ? w_g_onehot : '0;
   assign w_sleep_clr   = bus.sleep_req & r_enable & ~w_defer;
   assign w_timeout_clr = w_do_timeout ? w_g_onehot : '0;

   rr_priority_picker #(.N(NUM_DOMAINS)) u_picker (
      .req   (w_pending),
      .ptr   (r_ptr),
      .grant (w_pick_grant),
      .index (w_pick_idx),
      .any   (w_pick_any)
   );

   always_ff @(posedge ref_clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_do_grant   = 1'b0;
      w_do_ack     = 1'b0;
      w_do_timeout = 1'b0;
      case (r_state)
         IDLE: begin
            if ((|w_pending) && (r_active < c_CNT_W'(MAX_ACTIVE)))
               w_next_state = GRANT;
         end
         GRANT: begin
            if (w_pick_any) begin
               w_do_grant   = 1'b1;
               w_next_state = WAIT_VALID;
            end else begin
               w_next_state = IDLE;
            end
         end
         WAIT_VALID: begin
            if (bus.clock_valid[r_g]) begin
               w_do_ack     = 1'b1;
               w_next_state = SPACING;
            end else if (r_tmr == c_TMR_W'(WAKE_TIMEOUT - 1)) begin
               w_do_timeout = 1'b1;
               w_next_state = IDLE;
            end
         end
         SPACING: begin
            if (r_tmr == c_TMR_W'(WAKE_SPACING - 1))
               w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      w_popcount = '0;
      w_auto_clr = '0;
      for (int i = 0; i < NUM_DOMAINS; i++) begin
         w_popcount    = w_popcount + c_CNT_W'(r_enable[i]);
         w_auto_clr[i] = bus.auto_sleep_en && (r_idle[i] == c_IDL_W'(IDLE_TIMEOUT))
                         && r_enable[i] && !w_defer[i];
      end
   end

   always_ff @(posedge ref_clk) begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
         if (rst || bus.activity_detect[i] || !r_enable[i])
            r_idle[i] <= '0;
         else if (r_idle[i] != c_IDL_W'(IDLE_TIMEOUT))
            r_idle[i] <= r_idle[i] + 1'b1;
      end
   end

   always_ff @(posedge ref_clk) begin
      if (rst) begin
         r_ptr        <= '0;
         r_g          <= '0;
         r_tmr        <= '0;
         r_enable     <= '0;
         r_ack        <= '0;
         r_err        <= '0;
         r_active     <= '0;
         r_power_mode <= '0;
      end else begin
         r_power_mode <= bus.cfg_power_mode;
         r_active     <= w_popcount;
         r_ack        <= w_do_ack ? w_g_onehot : '0;
         r_err        <= (r_err & ~bus.sleep_req) | w_timeout_clr;
         r_enable     <= (r_enable & ~w_sleep_clr & ~w_auto_clr & ~w_timeout_clr)
                         | (w_do_grant ? w_pick_grant : '0);
         if (w_do_grant) begin
            r_g   <= w_pick_idx;
            r_ptr <= (w_pick_idx == c_IDX_W'(NUM_DOMAINS - 1)) ? '0 : w_pick_idx + 1'b1;
         end
         if (w_next_state != r_state)
            r_tmr <= '0;
         else if (r_state == WAIT_VALID || r_state == SPACING)
            r_tmr <= r_tmr + 1'b1;
      end
   end

   assign bus.domain_enable = r_enable;
   assign bus.power_mode    = r_power_mode;
   assign bus.wake_ack      = r_ack;
   assign bus.wake_err      = r_err;
   assign bus.active_count  = r_active;
   assign bus.busy          = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_clock_domain_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_domain_sequencer
// Purpose  : Directed bench with an ack scoreboard and a gating-unit model.
// Revision : 1.0
// ============================================================================
module tb_clock_domain_sequencer;
   import pwr_pkg::*;

   localparam int N  = 16;
   localparam int WS = 4;
   localparam int WT = 32;
   localparam int IT = 64;
   localparam int MA = 8;

   logic ref_clk = 1'b0;
   logic rst     = 1'b1;
   always #5 ref_clk = ~ref_clk;

   clock_domain_sequencer_if #(.NUM_DOMAINS(N)) bus ();

   clock_domain_sequencer #(
      .NUM_DOMAINS(N), .WAKE_SPACING(WS), .WAKE_TIMEOUT(WT),
      .IDLE_TIMEOUT(IT), .MAX_ACTIVE(MA)
   ) dut (
      .ref_clk (ref_clk),
      .rst     (rst),
      .bus     (bus.slave)
   );

   // Gating-unit stand-in: clock_valid follows domain_enable by two cycles.
   logic [N-1:0] r_v1, r_v2, valid_mask;
   always @(posedge ref_clk) begin
      if (rst) begin
         r_v1 <= '0;
         r_v2 <= '0;
      end else begin
         r_v1 <= bus.domain_enable;
         r_v2 <= r_v1;
      end
   end
   assign bus.clock_valid = r_v2 & ~valid_mask;

   int tests_run    = 0;
   int tests_failed = 0;
   int ack_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic bound_fail(input string tag);
      tests_run++;
      tests_failed++;
      $error("FAIL %s observed=timeout expected=event", tag);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge ref_clk);
   endtask

   task automatic wait_en(input int idx, input logic val, input int bound,
                          input string tag, output int k);
      bit found;
      found = 0;
      k     = 0;
      while (k < bound && !found) begin
         tick(1);
         k++;
         if (bus.domain_enable[idx] === val) found = 1;
      end
      if (!found) bound_fail(tag);
   endtask

   task automatic wait_quiet(input string tag);
      int q, n;
      q = 0;
      n = 0;
      while (q < 3 && n < 400) begin
         tick(1);
         n++;
         if (bus.busy === 1'b0) q++;
         else q = 0;
      end
      if (q < 3) bound_fail(tag);
   endtask

   // Scoreboard: each wake_ack pulse must match the next expected domain.
   always @(negedge ref_clk) begin
      if (rst !== 1'b1 && bus.wake_ack !== '0) begin
         if (ack_q.size() == 0) begin
            check("ack_unexpected", 32'(bus.wake_ack), 32'h0);
         end else begin
            int e;
            e = ack_q.pop_front();
            check("ack_order", 32'(bus.wake_ack), 32'(1) << e);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=no_finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      bus.wake_req        = '0;
      bus.sleep_req       = '0;
      bus.activity_detect = '0;
      bus.auto_sleep_en   = 1'b0;
      bus.cfg_power_mode  = PM_DEEP;
      valid_mask          = '0;
      rst                 = 1'b1;
      tick(3);
      check("rst_enable", 32'(bus.domain_enable), 32'h0);
      check("rst_ack",    32'(bus.wake_ack),      32'h0);
      check("rst_err",    32'(bus.wake_err),      32'h0);
      check("rst_count",  32'(bus.active_count),  32'h0);
      check("rst_busy",   32'(bus.busy),          32'h0);
      check("rst_pm",     32'(bus.power_mode),    32'h0);
      rst = 1'b0;
      tick(1);
      check("pm_deep", 32'(bus.power_mode), 32'(PM_DEEP));
      bus.cfg_power_mode = PM_OFF;
      tick(1);
      check("pm_off", 32'(bus.power_mode), 32'(PM_OFF));

      // 1: two requests, spacing between grants
      bus.wake_req = 16'h0005;
      ack_q.push_back(0);
      ack_q.push_back(2);
      tick(1);
      check("t1_busy_grant", 32'(bus.busy), 32'h1);
      check("t1_en_pre", 32'(bus.domain_enable), 32'h0);
      tick(1);
      check("t1_en0", 32'(bus.domain_enable), 32'h0001);
      k = 0;
      while (k < 10 && bus.wake_ack[0] !== 1'b1) begin
         tick(1);
         k++;
      end
      check("t1_ack_latency", 32'(k), 32'd3);
      tick(WS - 1);
      check("t1_spacing_hold", 32'(bus.busy), 32'h1);
      tick(1);
      check("t1_spacing_exit", 32'(bus.busy), 32'h0);
      tick(2);
      check("t1_en2", 32'(bus.domain_enable), 32'h0005);
      wait_quiet("t1_quiet");
      bus.wake_req = '0;
      check("t1_count", 32'(bus.active_count), 32'd2);

      // 2: pointer wrap 15 -> 0
      bus.sleep_req = 16'h0001;
      tick(1);
      bus.sleep_req = '0;
      check("t2_sleep0", 32'(bus.domain_enable), 32'h0004);
      bus.wake_req = 16'h4000;
      ack_q.push_back(14);
      wait_quiet("t2_q14");
      bus.wake_req = '0;
      check("t2_en14", 32'(bus.domain_enable), 32'h4004);
      bus.wake_req = 16'h8001;
      ack_q.push_back(15);
      ack_q.push_back(0);
      wait_quiet("t2_qwrap");
      bus.wake_req = '0;
      check("t2_en_wrap", 32'(bus.domain_enable), 32'hC005);

      // 3: fill to budget from pointer 1, then stall on domain 9
      bus.wake_req = 16'h026A;
      ack_q.push_back(1);
      ack_q.push_back(3);
      ack_q.push_back(5);
      ack_q.push_back(6);
      wait_quiet("t3_fill");
      tick(4);
      check("t3_busy_stall", 32'(bus.busy), 32'h0);
      check("t3_en_full", 32'(bus.domain_enable), 32'hC06F);
      check("t3_count", 32'(bus.active_count), 32'd8);
      ack_q.push_back(9);
      bus.wake_req  = 16'h0200;
      bus.sleep_req = 16'h0008;
      tick(1);
      bus.sleep_req = '0;
      check("t3_sleep3", 32'(bus.domain_enable), 32'hC067);
      wait_en(9, 1'b1, 20, "t3_wait9", k);
      check("t3_en9", 32'(bus.domain_enable), 32'hC267);
      wait_quiet("t3_q9");
      bus.wake_req = '0;
      check("t3_count9", 32'(bus.active_count), 32'd8);

      // 4: wake timeout on domain 4, sticky error
      bus.sleep_req = 16'hC000;
      tick(1);
      bus.sleep_req = '0;
      check("t4_sleep", 32'(bus.domain_enable), 32'h0267);
      valid_mask   = 16'h0010;
      bus.wake_req = 16'h0010;
      wait_en(4, 1'b1, 10, "t4_rise", k);
      k = 0;
      while (k < 40 && bus.domain_enable[4] === 1'b1) begin
         tick(1);
         k++;
      end
      check("t4_timeout_delay", 32'(k), 32'(WT));
      check("t4_err", 32'(bus.wake_err), 32'h0010);
      tick(8);
      check("t4_err_sticky", 32'(bus.wake_err), 32'h0010);
      check("t4_no_regrant", 32'(bus.domain_enable), 32'h0267);
      check("t4_idle", 32'(bus.busy), 32'h0);
      bus.wake_req  = '0;
      bus.sleep_req = 16'h0010;
      tick(1);
      bus.sleep_req = '0;
      check("t4_err_clr", 32'(bus.wake_err), 32'h0);
      valid_mask = '0;

      // 5: auto-sleep of domain 1, then restart by one activity pulse
      bus.sleep_req = 16'h0002;
      tick(1);
      bus.sleep_req = '0;
      check("t5_sleep1", 32'(bus.domain_enable), 32'h0265);
      bus.activity_detect = 16'hFFFD;
      tick(1);
      bus.auto_sleep_en = 1'b1;
      bus.wake_req      = 16'h0002;
      ack_q.push_back(1);
      wait_en(1, 1'b1, 10, "t5_rise", k);
      bus.wake_req = '0;
      k = 0;
      while (k < 100 && bus.domain_enable[1] === 1'b1) begin
         tick(1);
         k++;
      end
      check("t5_autosleep", 32'(k), 32'(IT + 1));
      check("t5_others_kept", 32'(bus.domain_enable), 32'h0265);
      bus.wake_req = 16'h0002;
      ack_q.push_back(1);
      wait_en(1, 1'b1, 10, "t5_rise2", k);
      bus.wake_req = '0;
      k = 0;
      while (k < 200 && bus.domain_enable[1] === 1'b1) begin
         tick(1);
         k++;
         if (k == 62)      bus.activity_detect = 16'hFFFF;
         else if (k == 63) bus.activity_detect = 16'hFFFD;
      end
      check("t5_restart", 32'(k), 32'(63 + IT + 1));
      bus.auto_sleep_en   = 1'b0;
      bus.activity_detect = '0;

      // 6: sleep beats wake; reset mid-wake
      bus.wake_req  = 16'h0080;
      bus.sleep_req = 16'h0080;
      k = 0;
      repeat (6) begin
         tick(1);
         if (bus.busy === 1'b1) k++;
      end
      check("t6_no_grant_busy", 32'(k), 32'h0);
      check("t6_no_en7", 32'(bus.domain_enable[7]), 32'h0);
      bus.sleep_req = '0;
      tick(3);
      check("t6_en7", 32'(bus.domain_enable[7]), 32'h1);
      rst = 1'b1;
      tick(1);
      check("t6_rst_enable", 32'(bus.domain_enable), 32'h0);
      check("t6_rst_ack",    32'(bus.wake_ack),      32'h0);
      check("t6_rst_count",  32'(bus.active_count),  32'h0);
      check("t6_rst_busy",   32'(bus.busy),          32'h0);
      check("t6_rst_pm",     32'(bus.power_mode),    32'h0);
      tick(1);
      bus.wake_req = '0;
      rst = 1'b0;
      tick(8);
      check("t6_post_enable", 32'(bus.domain_enable), 32'h0);
      check("sb_empty", 32'(ack_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
